// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 receiver: timing defaults, FSM states, pixel geometry.
// S_STUCK exists only when WS2812_RX_ERR_CHECK_EN is defined.
package ws2812_pkg;

  localparam int PIXEL_W           = 24;
  localparam int BIT_CNT_W         = $clog2(PIXEL_W);
  localparam int FRAME_CNT_W       = 9;
  localparam int DEF_SAMPLE_THRESH = 12;
  localparam int DEF_MIN_HIGH      = 4;
  localparam int DEF_MAX_HIGH      = 20;
  localparam int DEF_IDLE_LATCH    = 1000;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3
`ifdef WS2812_RX_ERR_CHECK_EN
    , S_STUCK = 3'd4
`endif
  } state_t;

  // Wire order is kept: the oldest bit migrates up to the MSB.
  function automatic logic [PIXEL_W-1:0] shift_in(input logic [PIXEL_W-1:0] cur, input logic b);
    return {cur[PIXEL_W-2:0], b};
  endfunction

endpackage

// File: rtl/sdi_edge_sync.sv
// Two-flop synchronizer for the asynchronous LED data pin plus one history flop
// for edge detection; all edges refer to the synchronized level.
module sdi_edge_sync
  import ws2812_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sdi,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and edge-history flop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_sdi;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-lane receiver: decodes pulse-width bits into 24-bit GRB pixels and frames.
// Define WS2812_RX_ERR_CHECK_EN to enable glitch / stuck-high / partial-pixel error reporting.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int SAMPLE_THRESH = DEF_SAMPLE_THRESH,
  parameter int MIN_HIGH      = DEF_MIN_HIGH,
  parameter int MAX_HIGH      = DEF_MAX_HIGH,
  parameter int IDLE_LATCH    = DEF_IDLE_LATCH
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_sdi,
  output logic [PIXEL_W-1:0]     o_pixel_data,
  output logic                   o_pixel_valid,
  output logic                   o_frame_done,
  output logic [FRAME_CNT_W-1:0] o_frame_pixels,
  output logic                   o_bit_err
);

  localparam int HIGH_W = $clog2(MAX_HIGH + 2);
  localparam int LOW_W  = $clog2(IDLE_LATCH + 1);
  localparam logic [HIGH_W-1:0]    C_THRESH   = HIGH_W'(SAMPLE_THRESH);
  localparam logic [HIGH_W-1:0]    C_MIN      = HIGH_W'(MIN_HIGH);
  localparam logic [HIGH_W-1:0]    C_HIGH_SAT = {HIGH_W{1'b1}};
  localparam logic [LOW_W-1:0]     C_LATCH    = LOW_W'(IDLE_LATCH);
  localparam logic [BIT_CNT_W-1:0] C_LAST_BIT = BIT_CNT_W'(PIXEL_W - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_level;
  logic                   w_rise;
  logic                   w_fall;
  logic [HIGH_W-1:0]      r_high_cnt;
  logic [LOW_W-1:0]       r_low_cnt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [PIXEL_W-1:0]     r_shift;
  logic [FRAME_CNT_W-1:0] r_pix_cnt;
  logic                   r_activity;
  logic                   w_latch;
  logic                   w_stuck;
  logic                   w_bit_done;
  logic                   w_short;
  logic                   w_bit_val;
  logic                   w_bit_take;
  logic                   w_pixel_done;
  logic                   w_frame_end;
  logic                   w_err;
  logic                   w_start_bit;
  logic [PIXEL_W-1:0]     w_shift_next;

  sdi_edge_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sdi   (i_sdi),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // The high counter counts the rising cycle itself, so at the falling edge it equals the high time.
  assign w_latch = (r_state == S_LOW) && (r_low_cnt >= C_LATCH);
`ifdef WS2812_RX_ERR_CHECK_EN
  localparam logic [HIGH_W-1:0] C_MAX = HIGH_W'(MAX_HIGH);
  assign w_stuck = (r_state == S_HIGH) && !w_fall && (r_high_cnt >= C_MAX);
`else
  assign w_stuck = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a rise coinciding with the latch both closes the frame and starts a bit
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (r_low_cnt >= C_LATCH) begin
          w_state_next = w_rise ? S_HIGH : S_IDLE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_IDLE: begin
        w_state_next = w_rise ? S_HIGH : S_IDLE;
      end
      S_HIGH: begin
        if (w_fall) begin
          w_state_next = S_LOW;
        end else if (w_stuck) begin
`ifdef WS2812_RX_ERR_CHECK_EN
          w_state_next = S_STUCK;
`else
          w_state_next = S_HIGH;
`endif
        end else begin
          w_state_next = S_HIGH;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_state_next = S_HIGH;
        end else if (w_latch) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_LOW;
        end
      end
`ifdef WS2812_RX_ERR_CHECK_EN
      S_STUCK: begin
        w_state_next = w_fall ? S_LOW : S_STUCK;
      end
`endif
      default: begin
        w_state_next = S_WAIT;
      end
    endcase
  end

  // Output decode: bit classification, pixel/frame completion and error events
  always_comb begin
    w_bit_done   = (r_state == S_HIGH) && w_fall;
    w_short      = (r_high_cnt < C_MIN);
    w_bit_val    = !w_short && (r_high_cnt >= C_THRESH);
    w_shift_next = shift_in(r_shift, w_bit_val);
`ifdef WS2812_RX_ERR_CHECK_EN
    w_bit_take   = w_bit_done && !w_short;
    w_err        = (w_bit_done && w_short) || w_stuck ||
                   (w_latch && (r_bit_cnt != {BIT_CNT_W{1'b0}}));
`else
    w_bit_take   = w_bit_done;
    w_err        = 1'b0;
`endif
    w_pixel_done = w_bit_take && (r_bit_cnt == C_LAST_BIT);
    w_frame_end  = w_latch && r_activity;
    w_start_bit  = (w_state_next == S_HIGH) && (r_state != S_HIGH);
  end

  // Datapath: counters, shift register and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_high_cnt     <= {HIGH_W{1'b0}};
      r_low_cnt      <= {LOW_W{1'b0}};
      r_bit_cnt      <= {BIT_CNT_W{1'b0}};
      r_shift        <= {PIXEL_W{1'b0}};
      r_pix_cnt      <= {FRAME_CNT_W{1'b0}};
      r_activity     <= 1'b0;
      o_pixel_data   <= {PIXEL_W{1'b0}};
      o_pixel_valid  <= 1'b0;
      o_frame_done   <= 1'b0;
      o_frame_pixels <= {FRAME_CNT_W{1'b0}};
      o_bit_err      <= 1'b0;
    end else begin
      o_pixel_valid <= w_pixel_done;
      o_frame_done  <= w_frame_end;
      o_bit_err     <= w_err;
      if (w_pixel_done) begin
        o_pixel_data <= w_shift_next;
      end
      if (w_frame_end) begin
        o_frame_pixels <= r_pix_cnt;
      end

      if (w_latch) begin
        r_pix_cnt <= {FRAME_CNT_W{1'b0}};
      end else if (w_pixel_done && (r_pix_cnt != {FRAME_CNT_W{1'b1}})) begin
        r_pix_cnt <= r_pix_cnt + FRAME_CNT_W'(1);
      end

      if (w_latch) begin
        r_activity <= 1'b0;
      end else if (w_bit_take) begin
        r_activity <= 1'b1;
      end

      if (w_latch || w_stuck) begin
        r_bit_cnt <= {BIT_CNT_W{1'b0}};
      end else if (w_bit_take) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= w_pixel_done ? {BIT_CNT_W{1'b0}} : r_bit_cnt + BIT_CNT_W'(1);
      end

      if (w_start_bit) begin
        r_high_cnt <= HIGH_W'(1);
      end else if ((r_state == S_HIGH) && (r_high_cnt != C_HIGH_SAT)) begin
        r_high_cnt <= r_high_cnt + HIGH_W'(1);
      end

      case (r_state)
        S_WAIT: begin
          if (w_level) begin
            r_low_cnt <= {LOW_W{1'b0}};
          end else if (r_low_cnt < C_LATCH) begin
            r_low_cnt <= r_low_cnt + LOW_W'(1);
          end
        end
        S_LOW: begin
          if (r_low_cnt < C_LATCH) begin
            r_low_cnt <= r_low_cnt + LOW_W'(1);
          end
        end
        default: begin
          if (w_fall) begin
            r_low_cnt <= LOW_W'(1);
          end
        end
      endcase
    end
  end

endmodule
